// File: rtl/trace_term_monitor_if.sv
// Trace-stream inputs and the arbitrated character stream of trace_term_monitor.
// The monitor takes the slave side; the environment (tiles or bench) takes the master side.
interface trace_term_monitor_if #(
  parameter int NUM_CORES = 4,
  parameter int CW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) ();
  logic [NUM_CORES-1:0]    trace_valid;
  logic [NUM_CORES*32-1:0] trace_insn;
  logic [NUM_CORES-1:0]    trace_wben;
  logic [NUM_CORES*5-1:0]  trace_wbreg;
  logic [NUM_CORES*32-1:0] trace_wbdata;
  logic                    char_valid;
  logic [7:0]              char_data;
  logic [CW-1:0]           char_core;
  logic                    char_ready;

  modport master (
    output trace_valid, trace_insn, trace_wben, trace_wbreg, trace_wbdata, char_ready,
    input  char_valid, char_data, char_core
  );

  modport slave (
    input  trace_valid, trace_insn, trace_wben, trace_wbreg, trace_wbdata, char_ready,
    output char_valid, char_data, char_core
  );
endinterface

// File: rtl/trace_term_monitor.sv
// Small generic FIFO with same-cycle fall-through when empty.
// Latency: 0 cycles (an incoming word is readable in the cycle it is written).
// Backpressure: wr_rdy drops when full unless the same cycle pops.
module ttm_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  input  logic         rd_rdy
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, do_wr, do_rd;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign rd_vld = !empty || wr_vld;
  assign rd_dat = empty ? wr_dat : mem[rd_ptr];
  assign wr_rdy = !full || rd_rdy;
  assign do_rd  = rd_rdy && !empty;
  // An empty FIFO popped while written passes the word straight through.
  assign do_wr  = wr_vld && wr_rdy && !(empty && rd_rdy);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Multi-core trace monitor: shadow r3, l.nop exit/putc decode, round-robin console, done/timeout.
// Latency: putc retired in cycle t is on char_valid in t+1; exit shows on term_core in t+1.
// Backpressure: char stream held until char_ready; per-core FIFOs drop and flag on overflow.
module trace_term_monitor #(
  parameter int NUM_CORES      = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TERM_MODE      = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  trace_term_monitor_if.slave     bus,
  output logic [NUM_CORES-1:0]    term_core,
  output logic [NUM_CORES*32-1:0] exit_code,
  output logic                    done,
  output logic                    timeout,
  output logic [NUM_CORES-1:0]    dropped
);
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef struct packed {
    logic        vld;
    logic [31:0] insn;
    logic        wben;
    logic [4:0]  wbreg;
    logic [31:0] wbdata;
  } trace_t;

  trace_t               tr [NUM_CORES];
  logic [31:0]          r3 [NUM_CORES];
  logic [7:0]           fifo_dat [NUM_CORES];
  logic [NUM_CORES-1:0] exit_ev, putc_ev, push_rdy, avail, pop, term_nxt;
  logic [CW-1:0]        ptr, gnt, ptr_nxt;
  logic [7:0]           sel_dat;
  logic                 load, found, cv_nxt, hit, done_set, to_hit, timeout_set;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    logic is_nop;

    assign tr[i] = '{vld:    bus.trace_valid[i],
                     insn:   bus.trace_insn[i*32 +: 32],
                     wben:   bus.trace_wben[i],
                     wbreg:  bus.trace_wbreg[i*5 +: 5],
                     wbdata: bus.trace_wbdata[i*32 +: 32]};

    assign is_nop     = tr[i].vld && (tr[i].insn[31:16] == 16'h1500);
    assign exit_ev[i] = is_nop && (tr[i].insn[15:0] == 16'h0001) && !term_core[i];
    assign putc_ev[i] = is_nop && (tr[i].insn[15:0] == 16'h0004) && !term_core[i];

    ttm_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (putc_ev[i]),
      .wr_dat (r3[i][7:0]),
      .wr_rdy (push_rdy[i]),
      .rd_vld (avail[i]),
      .rd_dat (fifo_dat[i]),
      .rd_rdy (pop[i])
    );
  end

  // Round-robin pick starting at ptr; the output register reloads when empty or transferring.
  always_comb begin
    int j;
    j       = 0;
    found   = 1'b0;
    gnt     = '0;
    sel_dat = '0;
    load    = !bus.char_valid || bus.char_ready;
    for (int k = 0; k < NUM_CORES; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      if (!found && avail[j]) begin
        found   = 1'b1;
        gnt     = CW'(j);
        sel_dat = fifo_dat[j];
      end
    end
    ptr_nxt = (gnt == CW'(NUM_CORES - 1)) ? '0 : gnt + CW'(1);
    for (int i = 0; i < NUM_CORES; i++) begin
      pop[i] = load && found && (gnt == CW'(i));
    end
    cv_nxt = load ? found : 1'b1;
  end

  // Termination looks at next-cycle state so a lone exit with nothing pending finishes in t+1.
  assign term_nxt    = term_core | exit_ev;
  assign hit         = (TERM_MODE != 0) ? |term_nxt : &term_nxt;
  assign done_set    = !done && !timeout && hit && !cv_nxt;
  assign timeout_set = to_hit && !done_set;

  if (TIMEOUT_CYCLES > 0) begin : g_to
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (!done && !timeout) begin
        cnt <= cnt + TW'(1);
      end
    end

    assign to_hit = !done && !timeout && (cnt == TW'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_to
    assign to_hit = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CORES; i++) r3[i] <= '0;
      term_core      <= '0;
      exit_code      <= '0;
      dropped        <= '0;
      ptr            <= '0;
      bus.char_valid <= 1'b0;
      bus.char_data  <= '0;
      bus.char_core  <= '0;
      done           <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (tr[i].vld && tr[i].wben && (tr[i].wbreg == 5'd3)) r3[i] <= tr[i].wbdata;
        if (exit_ev[i]) begin
          term_core[i]          <= 1'b1;
          exit_code[i*32 +: 32] <= r3[i];
        end
        if (putc_ev[i] && !push_rdy[i]) dropped[i] <= 1'b1;
      end
      if (load) begin
        bus.char_valid <= found;
        if (found) begin
          bus.char_data <= sel_dat;
          bus.char_core <= gnt;
          ptr           <= ptr_nxt;
        end
      end
      if (done_set)    done    <= 1'b1;
      if (timeout_set) timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_trace_term_monitor.sv
// Bench for trace_term_monitor: table of single-core trace events plus hand sequences for
// arbitration, overflow, r3 forwarding, termination, TERM_MODE 1 and timeout; char stream scoreboarded.
module tb_trace_term_monitor;
  localparam logic [31:0] PUTC = 32'h1500_0004;
  localparam logic [31:0] EXIT = 32'h1500_0001;
  localparam logic [31:0] ALU  = 32'hE063_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rst_to;

  trace_term_monitor_if #(.NUM_CORES(4)) bus_m ();
  trace_term_monitor_if #(.NUM_CORES(4)) bus_a ();
  trace_term_monitor_if #(.NUM_CORES(4)) bus_t ();

  logic [3:0]   term_m, term_a, term_t, drop_m, drop_a, drop_t;
  logic [127:0] code_m, code_a, code_t;
  logic         done_m, done_a, done_t, to_m, to_a, to_t;

  trace_term_monitor #(.NUM_CORES(4), .FIFO_DEPTH(8), .TERM_MODE(0), .TIMEOUT_CYCLES(0)) u_main (
    .clk(clk), .rst(rst), .bus(bus_m), .term_core(term_m), .exit_code(code_m),
    .done(done_m), .timeout(to_m), .dropped(drop_m));
  trace_term_monitor #(.NUM_CORES(4), .FIFO_DEPTH(8), .TERM_MODE(1), .TIMEOUT_CYCLES(0)) u_any (
    .clk(clk), .rst(rst), .bus(bus_a), .term_core(term_a), .exit_code(code_a),
    .done(done_a), .timeout(to_a), .dropped(drop_a));
  trace_term_monitor #(.NUM_CORES(4), .FIFO_DEPTH(8), .TERM_MODE(0), .TIMEOUT_CYCLES(100)) u_to (
    .clk(clk), .rst(rst_to), .bus(bus_t), .term_core(term_t), .exit_code(code_t),
    .done(done_t), .timeout(to_t), .dropped(drop_t));

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef logic [7:0] byte_q_t [$];
  typedef struct { int cyc; int core; logic [7:0] dat; } xfer_t;
  byte_q_t sb [4];
  xfer_t   log_q [$];

  typedef struct {
    int          c;
    logic        vld;
    logic [31:0] insn;
    logic        wben;
    logic [4:0]  wreg;
    logic [31:0] wdat;
    logic        push;
    logic [7:0]  ch;
    logic [3:0]  term;
    logic [31:0] code;
  } vec_t;
  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Scoreboard: a transfer is visible at the negedge before the edge that completes it.
  always @(negedge clk) begin
    if (bus_m.char_valid && bus_m.char_ready) begin
      int c;
      logic [7:0] e;
      c = int'(bus_m.char_core);
      log_q.push_back('{cyc_n, c, bus_m.char_data});
      if (sb[c].size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL stream_extra: got core %0d data %h, expected no character", c, bus_m.char_data);
      end else begin
        e = sb[c].pop_front();
        chk("stream_data", {24'h0, bus_m.char_data}, {24'h0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_m();
    bus_m.trace_valid  = '0;
    bus_m.trace_insn   = '0;
    bus_m.trace_wben   = '0;
    bus_m.trace_wbreg  = '0;
    bus_m.trace_wbdata = '0;
  endtask

  task automatic ev_m(input int c, input logic [31:0] insn, input logic wben,
                      input logic [4:0] r, input logic [31:0] dat);
    bus_m.trace_valid[c]          = 1'b1;
    bus_m.trace_insn[c*32 +: 32]  = insn;
    bus_m.trace_wben[c]           = wben;
    bus_m.trace_wbreg[c*5 +: 5]   = r;
    bus_m.trace_wbdata[c*32 +: 32] = dat;
  endtask

  initial begin
    int n0;
    vt[0]  = '{0, 1'b1, ALU,            1'b1, 5'd3, 32'h2A, 1'b0, 8'h00, 4'b0000, 32'h0};
    vt[1]  = '{1, 1'b1, ALU,            1'b1, 5'd3, 32'h41, 1'b0, 8'h00, 4'b0000, 32'h0};
    vt[2]  = '{1, 1'b1, ALU,            1'b1, 5'd4, 32'h99, 1'b0, 8'h00, 4'b0000, 32'h0};
    vt[3]  = '{1, 1'b1, PUTC,           1'b0, 5'd0, 32'h0,  1'b1, 8'h41, 4'b0000, 32'h0};
    vt[4]  = '{0, 1'b1, 32'h1500_0002,  1'b0, 5'd0, 32'h0,  1'b0, 8'h00, 4'b0000, 32'h0};
    vt[5]  = '{0, 1'b1, 32'h1400_0001,  1'b0, 5'd0, 32'h0,  1'b0, 8'h00, 4'b0000, 32'h0};
    vt[6]  = '{2, 1'b0, PUTC,           1'b1, 5'd3, 32'h66, 1'b0, 8'h00, 4'b0000, 32'h0};
    vt[7]  = '{2, 1'b1, PUTC,           1'b0, 5'd0, 32'h0,  1'b1, 8'h55, 4'b0000, 32'h0};
    vt[8]  = '{0, 1'b1, EXIT,           1'b0, 5'd0, 32'h0,  1'b0, 8'h00, 4'b0001, 32'h2A};
    vt[9]  = '{0, 1'b1, PUTC,           1'b0, 5'd0, 32'h0,  1'b0, 8'h00, 4'b0001, 32'h2A};
    vt[10] = '{0, 1'b1, ALU,            1'b1, 5'd3, 32'h77, 1'b0, 8'h00, 4'b0001, 32'h2A};
    vt[11] = '{0, 1'b1, EXIT,           1'b0, 5'd0, 32'h0,  1'b0, 8'h00, 4'b0001, 32'h2A};

    rst = 1'b1;
    rst_to = 1'b1;
    idle_m();
    bus_m.char_ready = 1'b1;
    bus_a.trace_valid = '0; bus_a.trace_insn = '0; bus_a.trace_wben = '0;
    bus_a.trace_wbreg = '0; bus_a.trace_wbdata = '0; bus_a.char_ready = 1'b1;
    bus_t.trace_valid = '0; bus_t.trace_insn = '0; bus_t.trace_wben = '0;
    bus_t.trace_wbreg = '0; bus_t.trace_wbdata = '0; bus_t.char_ready = 1'b1;
    repeat (2) tick();

    chk("rst_char_valid", {31'h0, bus_m.char_valid}, 32'h0);
    chk("rst_char_data",  {24'h0, bus_m.char_data}, 32'h0);
    chk("rst_term_core",  {28'h0, term_m}, 32'h0);
    chk("rst_exit_code",  code_m[31:0] | code_m[63:32] | code_m[95:64] | code_m[127:96], 32'h0);
    chk("rst_done",       {31'h0, done_m}, 32'h0);
    chk("rst_timeout",    {31'h0, to_t}, 32'h0);
    chk("rst_dropped",    {28'h0, drop_m}, 32'h0);
    rst = 1'b0;
    tick();

    // Four simultaneous putcs: A..D on consecutive cycles, the first one cycle after retire.
    for (int c = 0; c < 4; c++) ev_m(c, ALU, 1'b1, 5'd3, 32'h41 + c);
    tick();
    idle_m();
    for (int c = 0; c < 4; c++) begin
      ev_m(c, PUTC, 1'b0, 5'd0, 32'h0);
      sb[c].push_back(8'h41 + 8'(c));
    end
    tick();
    idle_m();
    for (int c = 0; c < 4; c++) begin
      chk("rr_valid", {31'h0, bus_m.char_valid}, 32'h1);
      chk("rr_data",  {24'h0, bus_m.char_data}, 32'h41 + c);
      chk("rr_core",  {30'h0, bus_m.char_core}, c);
      tick();
    end
    chk("rr_idle", {31'h0, bus_m.char_valid}, 32'h0);

    // Overflow: core 2's char held in the output register, core 1 fills its FIFO and loses the 9th.
    bus_m.char_ready = 1'b0;
    ev_m(2, PUTC, 1'b0, 5'd0, 32'h0);
    ev_m(1, ALU, 1'b1, 5'd3, 32'h30);
    sb[2].push_back(8'h43);
    tick();
    chk("ovf_held_core", {30'h0, bus_m.char_core}, 32'h2);
    for (int k = 0; k < 9; k++) begin
      idle_m();
      ev_m(1, PUTC, 1'b1, 5'd3, 32'h31 + k);
      if (k < 8) sb[1].push_back(8'h30 + 8'(k));
      tick();
      if (k == 7) chk("ovf_full_no_drop", {28'h0, drop_m}, 32'h0);
    end
    idle_m();
    chk("ovf_dropped", {28'h0, drop_m}, 32'h2);
    chk("ovf_held_data", {24'h0, bus_m.char_data}, 32'h43);
    n0 = log_q.size();
    bus_m.char_ready = 1'b1;
    repeat (10) tick();
    chk("ovf_xfer_count", log_q.size() - n0, 32'd9);
    if (log_q.size() - n0 == 9) begin
      for (int k = 1; k < 9; k++) begin
        chk("ovf_no_bubble", log_q[n0 + k].cyc, log_q[n0].cyc + k);
        chk("ovf_core", log_q[n0 + k].core, 32'd1);
      end
    end

    // r3 written and putc retired together: the putc uses the old r3.
    ev_m(2, PUTC, 1'b1, 5'd3, 32'h55);
    sb[2].push_back(8'h43);
    tick();
    chk("fwd_old_r3", {24'h0, bus_m.char_data}, 32'h43);
    idle_m();
    ev_m(2, PUTC, 1'b0, 5'd0, 32'h0);
    sb[2].push_back(8'h55);
    tick();
    chk("fwd_new_r3", {24'h0, bus_m.char_data}, 32'h55);
    idle_m();
    tick();

    for (int v = 0; v < 12; v++) begin
      idle_m();
      ev_m(vt[v].c, vt[v].insn, vt[v].wben, vt[v].wreg, vt[v].wdat);
      bus_m.trace_valid[vt[v].c] = vt[v].vld;
      if (vt[v].push) sb[vt[v].c].push_back(vt[v].ch);
      tick();
      chk("vec_term_core", {28'h0, term_m}, {28'h0, vt[v].term});
      chk("vec_exit_code", code_m[vt[v].c*32 +: 32], vt[v].code);
      chk("vec_done", {31'h0, done_m}, 32'h0);
    end
    idle_m();
    repeat (2) tick();

    // Remaining cores exit while core 3 still has two characters pending.
    bus_m.char_ready = 1'b0;
    ev_m(3, PUTC, 1'b0, 5'd0, 32'h0);
    sb[3].push_back(8'h44);
    tick();
    idle_m();
    ev_m(3, PUTC, 1'b0, 5'd0, 32'h0);
    sb[3].push_back(8'h44);
    tick();
    idle_m();
    for (int c = 1; c < 4; c++) ev_m(c, EXIT, 1'b0, 5'd0, 32'h0);
    tick();
    idle_m();
    chk("term_all", {28'h0, term_m}, 32'hF);
    chk("code_core1", code_m[63:32], 32'h41);
    chk("code_core2", code_m[95:64], 32'h55);
    chk("code_core3", code_m[127:96], 32'h44);
    repeat (2) tick();
    chk("done_wait_pending", {31'h0, done_m}, 32'h0);
    bus_m.char_ready = 1'b1;
    tick();
    chk("done_one_left", {31'h0, done_m}, 32'h0);
    tick();
    chk("done_after_last", {31'h0, done_m}, 32'h1);
    chk("done_stream_idle", {31'h0, bus_m.char_valid}, 32'h0);
    chk("done_no_timeout", {31'h0, to_m}, 32'h0);
    chk("sb_drained", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), 32'd0);

    // TERM_MODE 1: one exit with nothing pending finishes the next cycle; later putcs still flow.
    chk("any_done_before", {31'h0, done_a}, 32'h0);
    bus_a.trace_valid[2] = 1'b1;
    bus_a.trace_insn[95:64] = EXIT;
    tick();
    bus_a.trace_valid = '0;
    bus_a.trace_insn = '0;
    chk("any_term", {28'h0, term_a}, 32'h4);
    chk("any_done", {31'h0, done_a}, 32'h1);
    bus_a.trace_valid[1] = 1'b1;
    bus_a.trace_insn[63:32] = PUTC;
    tick();
    bus_a.trace_valid = '0;
    bus_a.trace_insn = '0;
    chk("any_late_putc", {31'h0, bus_a.char_valid}, 32'h1);
    chk("any_late_core", {30'h0, bus_a.char_core}, 32'h1);
    tick();
    chk("any_done_sticky", {31'h0, done_a}, 32'h1);

    // Timeout at cycle 100, reset clears it immediately, and the count restarts.
    rst_to = 1'b0;
    repeat (99) tick();
    chk("to_before", {31'h0, to_t}, 32'h0);
    tick();
    chk("to_fire", {31'h0, to_t}, 32'h1);
    chk("to_no_done", {31'h0, done_t}, 32'h0);
    rst_to = 1'b1;
    #1;
    chk("to_async_clear", {31'h0, to_t}, 32'h0);
    tick();
    rst_to = 1'b0;
    repeat (50) tick();
    rst_to = 1'b1;
    #1;
    chk("to_mid_rst", {31'h0, to_t}, 32'h0);
    chk("to_mid_rst_valid", {31'h0, bus_t.char_valid}, 32'h0);
    tick();
    rst_to = 1'b0;
    repeat (99) tick();
    chk("to_restart_before", {31'h0, to_t}, 32'h0);
    tick();
    chk("to_restart_fire", {31'h0, to_t}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/trace_term_monitor.md
Name: trace_term_monitor

Overview:
- Parametrised successor to the per-core r3 checker and trace monitor pair used in compute-tile simulation.
- Watches NUM_CORES retired-instruction trace streams in one block:
  - keeps a shadow r3 per core;
  - decodes OpenRISC l.nop simulation codes (exit, putc);
  - buffers putc characters per core and emits them on one round-robin arbitrated character stream;
  - raises a global done under a configurable ALL/ANY termination policy, with an optional cycle timeout.
- Sits in the system testbench next to the compute tiles. It is synthesizable, so FPGA builds can reuse it for console and exit detection.

Parameters:
NUM_CORES, 4, number of monitored trace streams (>=1)
FIFO_DEPTH, 8, per-core character FIFO depth (power of 2, >=2)
TERM_MODE, 0, 0 = done when all cores exited; 1 = done when any core exited
TIMEOUT_CYCLES, 0, cycles after reset before timeout fires; 0 disables the timeout
CW, $clog2(NUM_CORES) (min 1), core-index width (localparam)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
trace_valid  in  NUM_CORES  per-core instruction-retired strobe
trace_insn  in  NUM_CORES*32  retired instruction word
trace_wben  in  NUM_CORES  register writeback enable
trace_wbreg  in  NUM_CORES*5  writeback register index
trace_wbdata  in  NUM_CORES*32  writeback data
char_valid  out  1  character available
char_data  out  8  character byte
char_core  out  CW  originating core
char_ready  in  1  consumer accepts character
term_core  out  NUM_CORES  sticky per-core exited flag
exit_code  out  NUM_CORES*32  r3 captured at exit
done  out  1  sticky global termination
timeout  out  1  sticky timeout flag
dropped  out  NUM_CORES  sticky per-core FIFO-overflow flag

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. On reset every output is 0; shadow r3 = 0, FIFOs empty, round-robin pointer = 0, timeout counter = 0. Reset mid-operation discards buffered characters with no partial output.

Shadow r3:
- Core i updates its shadow r3 when trace_valid[i] && trace_wben[i] && trace_wbreg[i]==3, taking effect at the clock edge.
- A nop decoded in the same cycle uses the pre-update value.

Nop decode:
- A nop is insn[31:16]==16'h1500. K = insn[15:0], sampled only when trace_valid[i].
- K=0x0001 (exit): term_core[i]<=1 and exit_code[i]<=r3 (only if term_core[i] was 0).
- K=0x0004 (putc): push r3[7:0] into FIFO i.
- All other K values are ignored.
- Once term_core[i] is set, all later putc/exit events from core i are ignored. Characters already buffered still drain.

FIFO full:
- A push to full FIFO i is dropped and dropped[i]<=1 (sticky). The FIFO contents are unchanged.
- A push and a pop on the same FIFO in the same cycle are both performed, so a full FIFO with a simultaneous pop accepts the push.

Output stream:
- Registered valid/ready. char_valid, char_data and char_core are held stable until char_ready.
- A transfer occurs when char_valid && char_ready.
- Minimum latency: putc retired at cycle t can appear on char_valid at t+1.
- Arbiter: when no character is held or the held one transfers, select the lowest non-empty FIFO index at or after the pointer (wrapping). After granting core g, the pointer becomes (g+1) mod NUM_CORES.
- Back-to-back transfers at 1 char/cycle are required when char_ready stays high.

Termination:
- term_hit = &term_core (TERM_MODE 0) or |term_core (TERM_MODE 1).
- done<=1 when term_hit && all FIFOs empty && !char_valid. It is sticky until reset.
- Pending characters therefore delay done. In TERM_MODE 1, non-exited cores keep pushing until done is set; done is then final and later events are still accepted but do not clear done.

Timeout:
- When TIMEOUT_CYCLES>0, a counter increments each cycle after reset.
- When the counter reaches TIMEOUT_CYCLES while done==0, timeout<=1 (sticky) and the counter freezes. The counter also freezes on done.
- done and timeout are mutually exclusive: after timeout, done never asserts.

Test Plan:
- Core 0 writes r3=0x2A (wben, wbreg=3), then retires insn 0x15000001 -> next cycle term_core=0001, exit_code[0]=0x0000002A; done stays 0 in TERM_MODE 0 with NUM_CORES=4.
- Cores 0-3 each putc 'A'+i in the same cycle with char_ready=1 -> stream 'A','B','C','D' with char_core 0,1,2,3 on four consecutive cycles, first at t+1.
- char_ready=0 while core 1 issues 9 putcs (FIFO_DEPTH=8) -> dropped=0010; after raising char_ready, exactly 8 chars drain in order with no bubbles.
- Same cycle: core 2 writes r3=0x55 and retires putc -> emitted char is the old r3 byte; a following putc emits 0x55.
- All four cores exit while core 3 still holds 2 buffered chars -> done asserts the cycle after the last char transfers, not before; TERM_MODE=1 variant: a single exit plus empty FIFOs gives done at t+1.
- TIMEOUT_CYCLES=100, no exits -> timeout=1 at cycle 100, done stays 0; assert rst at cycle 50 of a rerun -> all outputs 0 immediately, counter restarts.
